// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states, owner tags
// and the widths of the access counter and MEM streak counter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WAIT = 2'd1,
    ARB_ACK  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  // Both LATENCY and MAX_STREAK are limited to 15, so 4 bits suffice.
  localparam int COUNT_W  = 4;
  localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_arbiter_priority.sv
// Combinational grant decision between IF and MEM, with the MEM-streak
// update that keeps IF from starving behind back-to-back data accesses.
module arb_priority
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_STREAK = 4
) (
  input  logic                if_req,
  input  logic                mem_req,
  input  logic [STREAK_W-1:0] streak,
  output logic                grant_valid,
  output owner_e              grant_owner,
  output logic [STREAK_W-1:0] streak_next
);

  logic if_forced;

  always_comb begin
    if_forced   = if_req && (streak >= STREAK_W'(MAX_STREAK));
    grant_valid = if_req | mem_req;
    grant_owner = (mem_req && !if_forced) ? OWN_MEM : OWN_IF;
    streak_next = '0;
    // MEM can only beat a pending IF while streak < MAX_STREAK, so the
    // increment never overflows and saturates naturally.
    if (mem_req && !if_forced && if_req) begin
      streak_next = streak + STREAK_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-ported memory between instruction fetch and
// data access: arbitrate in IDLE, issue and wait in WAIT, pulse the ack in ACK.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2,
  parameter int MAX_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ack,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  mem_ren,
  input  logic                  mem_wen,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_ack,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  stall_if,
  output logic                  stall_mem,
  output logic                  conflict
);

  arb_state_e            state_reg, state_next;
  logic [COUNT_W-1:0]    count_reg;
  logic [STREAK_W-1:0]   streak_reg, streak_next;
  owner_e                owner_reg, grant_owner;
  logic                  write_reg;
  logic                  grant_valid, grant_mem, mem_req, last_wait;
  logic                  ram_en_reg, ram_we_reg, conflict_reg;
  logic                  if_ack_reg, mem_ack_reg;
  logic [ADDR_WIDTH-1:0] ram_addr_reg;
  logic [DATA_WIDTH-1:0] ram_wdata_reg, if_rdata_reg, mem_rdata_reg;

  assign mem_req   = mem_ren | mem_wen;
  assign grant_mem = (grant_owner == OWN_MEM);
  assign last_wait = (count_reg == COUNT_W'(LATENCY));

  arb_priority #(.MAX_STREAK(MAX_STREAK)) u_prio (
    .if_req      (if_req),
    .mem_req     (mem_req),
    .streak      (streak_reg),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner),
    .streak_next (streak_next)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ARB_IDLE: if (grant_valid) state_next = ARB_WAIT;
      ARB_WAIT: if (last_wait) state_next = ARB_ACK;
      ARB_ACK:  state_next = ARB_IDLE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ARB_IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg     <= '0;
      streak_reg    <= '0;
      owner_reg     <= OWN_IF;
      write_reg     <= 1'b0;
      ram_en_reg    <= 1'b0;
      ram_we_reg    <= 1'b0;
      conflict_reg  <= 1'b0;
      if_ack_reg    <= 1'b0;
      mem_ack_reg   <= 1'b0;
      ram_addr_reg  <= '0;
      ram_wdata_reg <= '0;
      if_rdata_reg  <= '0;
      mem_rdata_reg <= '0;
    end else begin
      // Strobes and acks are single-cycle pulses unless re-armed below.
      ram_en_reg   <= 1'b0;
      ram_we_reg   <= 1'b0;
      conflict_reg <= 1'b0;
      if_ack_reg   <= 1'b0;
      mem_ack_reg  <= 1'b0;
      case (state_reg)
        ARB_IDLE: begin
          streak_reg <= streak_next;
          if (grant_valid) begin
            owner_reg     <= grant_owner;
            write_reg     <= grant_mem & mem_wen;
            ram_en_reg    <= 1'b1;
            ram_we_reg    <= grant_mem & mem_wen;
            conflict_reg  <= grant_mem & mem_ren & mem_wen;
            ram_addr_reg  <= grant_mem ? mem_addr : if_addr;
            ram_wdata_reg <= mem_wdata;
            count_reg     <= '0;
          end
        end
        ARB_WAIT: begin
          count_reg <= count_reg + COUNT_W'(1);
          if (last_wait) begin
            if_ack_reg  <= (owner_reg == OWN_IF);
            mem_ack_reg <= (owner_reg == OWN_MEM);
            if (!write_reg) begin
              if (owner_reg == OWN_MEM) mem_rdata_reg <= ram_rdata;
              else                      if_rdata_reg  <= ram_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ram_en    = ram_en_reg;
  assign ram_we    = ram_we_reg;
  assign ram_addr  = ram_addr_reg;
  assign ram_wdata = ram_wdata_reg;
  assign conflict  = conflict_reg;
  assign if_ack    = if_ack_reg;
  assign mem_ack   = mem_ack_reg;
  assign if_rdata  = if_rdata_reg;
  assign mem_rdata = mem_rdata_reg;
  assign stall_if  = if_req & ~if_ack_reg;
  assign stall_mem = mem_req & ~mem_ack_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle by a schedule model.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0, mem_ren = 1'b0, mem_wen = 1'b0;
  logic [AW-1:0] if_addr = '0, mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0;
  logic          if_ack, mem_ack, ram_en, ram_we, stall_if, stall_mem, conflict;
  logic [DW-1:0] if_rdata, mem_rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(LAT), .MAX_STREAK(MAXS)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .stall_if(stall_if), .stall_mem(stall_mem), .conflict(conflict)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(i * 17));
  endfunction

  // Memory macro: fixed read latency LAT after the ram_en cycle.
  logic [31:0] ram_mem [0:63];
  logic [31:0] rd_pipe [0:LAT-1];
  initial for (int i = 0; i < 64; i++) ram_mem[i] = init_word(i);
  always @(posedge clk) begin
    if (ram_en && ram_we) ram_mem[ram_addr[7:2]] <= ram_wdata;
    rd_pipe[0] <= (ram_en && !ram_we) ? ram_mem[ram_addr[7:2]] : 32'h0BAD0BAD;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_rdata = rd_pipe[LAT-1];

  // Schedule model: a grant at cycle g means strobe at g+1, ack at g+LAT+2,
  // arbiter free again at g+LAT+3.
  int          cyc = 0, g_cyc = 0, m_streak = 0;
  bit          m_busy = 0, m_mem = 0, m_write = 0, m_conf = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_data = 0, exp_if_rdata = 0, exp_mem_rdata = 0;
  logic [31:0] shadow [0:63];
  initial for (int i = 0; i < 64; i++) shadow[i] = init_word(i);

  always @(negedge clk) begin : cmp
    logic e_en, e_ifack, e_memack;
    cyc++;
    if (!rst_n) begin
      m_busy = 0; m_streak = 0; exp_if_rdata = 0; exp_mem_rdata = 0;
      check("rst_pulses", {27'd0, ram_en, ram_we, if_ack, mem_ack, conflict}, 32'd0);
      check("rst_if_rdata", if_rdata, 32'd0);
      check("rst_mem_rdata", mem_rdata, 32'd0);
    end else begin
      if (m_busy && cyc >= g_cyc + LAT + 3) m_busy = 0;
      e_en     = m_busy && (cyc == g_cyc + 1);
      e_ifack  = m_busy && (cyc == g_cyc + LAT + 2) && !m_mem;
      e_memack = m_busy && (cyc == g_cyc + LAT + 2) && m_mem;
      if (e_ifack) exp_if_rdata = m_data;
      if (e_memack && !m_write) exp_mem_rdata = m_data;
      check("ram_en", {31'd0, ram_en}, {31'd0, e_en});
      check("ram_we", {31'd0, ram_we}, {31'd0, e_en && m_write});
      check("conflict", {31'd0, conflict}, {31'd0, e_en && m_conf});
      check("if_ack", {31'd0, if_ack}, {31'd0, e_ifack});
      check("mem_ack", {31'd0, mem_ack}, {31'd0, e_memack});
      check("if_rdata", if_rdata, exp_if_rdata);
      check("mem_rdata", mem_rdata, exp_mem_rdata);
      check("stall_if", {31'd0, stall_if}, {31'd0, if_req && !e_ifack});
      check("stall_mem", {31'd0, stall_mem}, {31'd0, (mem_ren || mem_wen) && !e_memack});
      if (m_busy && cyc >= g_cyc + 1 && cyc <= g_cyc + LAT + 1) begin
        check("ram_addr", ram_addr, m_addr);
        if (m_write) check("ram_wdata", ram_wdata, m_wdata);
      end
      if (!m_busy) begin
        if (if_req || mem_ren || mem_wen) begin
          m_mem = (mem_ren || mem_wen) && !(if_req && m_streak >= MAXS);
          m_streak = (m_mem && if_req) ? m_streak + 1 : 0;
          m_write = m_mem && mem_wen;
          m_conf  = m_mem && mem_ren && mem_wen;
          m_addr  = m_mem ? mem_addr : if_addr;
          m_wdata = mem_wdata;
          if (m_write) shadow[m_addr[7:2]] = m_wdata;
          else         m_data = shadow[m_addr[7:2]];
          m_busy = 1; g_cyc = cyc;
        end else begin
          m_streak = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_mem(input bit re, input bit we, input logic [31:0] a, input logic [31:0] d,
                        output int ack_at, output int we_cnt, output int conf_cnt,
                        output int conf_first, output logic [31:0] rd_at_ack);
    mem_ren = re; mem_wen = we; mem_addr = a; mem_wdata = d;
    ack_at = -1; we_cnt = 0; conf_cnt = 0; conf_first = -1; rd_at_ack = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (ram_en && ram_we) we_cnt++;
      if (conflict) begin conf_cnt++; if (conf_first < 0) conf_first = c; end
      if (ack_at >= 0 && c == ack_at + 1) begin mem_ren = 0; mem_wen = 0; end
      if (mem_ack && ack_at < 0) begin ack_at = c; rd_at_ack = mem_rdata; end
    end
    mem_ren = 0; mem_wen = 0;
  endtask

  initial begin : drive
    int a_at, w_cnt, c_cnt, c_first, m_at, i_at, nacks;
    logic [31:0] rd, seq;
    bit drop_if, drop_mem, prev_if, prev_mem;
    int r;

    repeat (3) tick();
    check("reset_if_ack", {31'd0, if_ack}, 32'd0);
    rst_n = 1;
    repeat (2) tick();

    // Single IF read of the preset word.
    if_req = 1; if_addr = 32'h10; #1;
    check("t1_stall_c0", {31'd0, stall_if}, 32'd1);
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) begin
        check("t1_ram_en_c1", {31'd0, ram_en}, 32'd1);
        check("t1_ram_we_c1", {31'd0, ram_we}, 32'd0);
      end
      if (c <= 3) begin
        check("t1_stall_if", {31'd0, stall_if}, 32'd1);
        check("t1_no_ack", {31'd0, if_ack}, 32'd0);
      end
      if (c == 4) begin
        check("t1_if_ack_c4", {31'd0, if_ack}, 32'd1);
        check("t1_if_rdata", if_rdata, 32'hDEADBEEF);
        check("t1_stall_c4", {31'd0, stall_if}, 32'd0);
        if_req = 0;
      end
      if (c == 5) check("t1_ack_once", {31'd0, if_ack}, 32'd0);
    end
    repeat (2) tick();

    // Simultaneous requests: MEM first, IF granted in the following IDLE.
    if_req = 1; if_addr = 32'h14; mem_ren = 1; mem_addr = 32'h18;
    m_at = -1; i_at = -1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (m_at >= 0 && c == m_at + 1) mem_ren = 0;
      if (i_at >= 0 && c == i_at + 1) if_req = 0;
      if (mem_ack && m_at < 0) begin m_at = c; rd = mem_rdata; end
      if (if_ack && i_at < 0) i_at = c;
    end
    mem_ren = 0; if_req = 0;
    check("t2_mem_ack_cycle", 32'(m_at), 32'd4);
    check("t2_if_ack_cycle", 32'(i_at), 32'd9);
    check("t2_mem_rdata", rd, init_word(6));
    check("t2_if_rdata", if_rdata, init_word(5));

    // Write then read back; mem_rdata keeps the previous read on a write ack.
    do_mem(0, 1, 32'h20, 32'h12345678, a_at, w_cnt, c_cnt, c_first, rd);
    check("t3_wr_ack_cycle", 32'(a_at), 32'd4);
    check("t3_we_pulses", 32'(w_cnt), 32'd1);
    check("t3_rdata_held", rd, init_word(6));
    do_mem(1, 0, 32'h20, 32'h0, a_at, w_cnt, c_cnt, c_first, rd);
    check("t3_readback", rd, 32'h12345678);
    check("t3_rd_no_we", 32'(w_cnt), 32'd0);

    // Conflicting read+write is performed as a write.
    do_mem(1, 1, 32'h24, 32'hA5A5A5A5, a_at, w_cnt, c_cnt, c_first, rd);
    check("t5_conflict_count", 32'(c_cnt), 32'd1);
    check("t5_conflict_cycle", 32'(c_first), 32'd1);
    check("t5_is_write", 32'(w_cnt), 32'd1);
    do_mem(1, 0, 32'h24, 32'h0, a_at, w_cnt, c_cnt, c_first, rd);
    check("t5_readback", rd, 32'hA5A5A5A5);

    // Fairness: back-to-back MEM with IF pending, ack order M M M M I M.
    if_req = 1; if_addr = 32'h30; mem_ren = 1; mem_addr = 32'h34;
    seq = 0; nacks = 0; drop_if = 0; drop_mem = 0;
    for (int c = 1; c <= 60 && nacks < 6; c++) begin
      tick();
      if (drop_if) begin if_req = 0; drop_if = 0; end
      if (mem_ack) begin seq = {seq[30:0], 1'b1}; nacks++; end
      if (if_ack) begin seq = {seq[30:0], 1'b0}; nacks++; drop_if = 1; end
    end
    tick();
    if_req = 0; mem_ren = 0;
    check("t4_ack_order", seq, 32'h3D);
    repeat (6) tick();

    // Reset in cycle 2 of an IF access abandons it.
    if_req = 1; if_addr = 32'h10;
    tick(); tick();
    rst_n = 0; #1;
    check("t6_rst_ram_en", {31'd0, ram_en}, 32'd0);
    check("t6_rst_mem_rdata", mem_rdata, 32'd0);
    check("t6_rst_if_rdata", if_rdata, 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t6_no_ack", {31'd0, if_ack}, 32'd0);
    end
    rst_n = 1;
    i_at = -1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (if_ack && i_at < 0) begin i_at = c; rd = if_rdata; if_req = 0; end
    end
    if_req = 0;
    check("t6_fresh_ack_cycle", 32'(i_at), 32'd4);
    check("t6_fresh_rdata", rd, 32'hDEADBEEF);
    repeat (2) tick();

    // Randomized traffic respecting the request/renew protocol.
    prev_if = 0; prev_mem = 0;
    for (int n = 0; n < 4000; n++) begin
      tick();
      if (prev_if) begin
        if ($urandom_range(0, 1) == 1) if_addr = 32'($urandom_range(0, 63)) << 2;
        else if_req = 0;
      end else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = 32'($urandom_range(0, 63)) << 2;
      end
      if (prev_mem || (!(mem_ren || mem_wen) && $urandom_range(0, 2) == 0)) begin
        if (prev_mem && $urandom_range(0, 1) == 0) begin
          mem_ren = 0; mem_wen = 0;
        end else begin
          r = $urandom_range(0, 9);
          mem_ren = (r < 5) || (r == 9);
          mem_wen = (r >= 5);
          mem_addr = 32'($urandom_range(0, 63)) << 2;
          mem_wdata = $urandom;
        end
      end
      prev_if = if_ack; prev_mem = mem_ack;
    end
    if_req = 0; mem_ren = 0; mem_wen = 0;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the pipeline's instruction-fetch port (IF) and its data-access port (MEM).
- Sequences each access through issue, wait and acknowledge.
- Produces the stall signals that freeze the pipeline while an access is outstanding.
- Sits between the 5-stage pipeline and the memory macro. The decoder's mem_ren/mem_wen drive the MEM port.

Parameters:
- ADDR_WIDTH, 32, byte address width of all ports.
- DATA_WIDTH, 32, data width.
- LATENCY, 2, cycles from the RAM issue cycle to valid ram_rdata; legal range 1..15.
- MAX_STREAK, 4, consecutive MEM grants allowed while IF is waiting before IF is forced to win; legal range 1..15.

Ports:
- clk  in  1  main clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  IF read request; level, held until if_ack.
- if_addr  in  ADDR_WIDTH  IF address; stable while if_req=1.
- if_ack  out  1  one-cycle pulse; IF access complete.
- if_rdata  out  DATA_WIDTH  IF read data; valid from if_ack until the next if_ack.
- mem_ren  in  1  data read request; level, held until mem_ack.
- mem_wen  in  1  data write request; level, held until mem_ack.
- mem_addr  in  ADDR_WIDTH  data address.
- mem_wdata  in  DATA_WIDTH  write data.
- mem_ack  out  1  one-cycle pulse; data access complete.
- mem_rdata  out  DATA_WIDTH  read data; valid from mem_ack until the next mem_ack.
- ram_en  out  1  RAM access strobe; asserted for exactly one cycle per access.
- ram_we  out  1  RAM write strobe; qualified by ram_en.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_rdata  in  DATA_WIDTH  RAM read data; valid LATENCY cycles after the ram_en cycle.
- stall_if  out  1  equals if_req & ~if_ack.
- stall_mem  out  1  equals (mem_ren | mem_wen) & ~mem_ack.
- conflict  out  1  one-cycle pulse when a MEM grant sees mem_ren and mem_wen both high.

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE, counter=0, streak=0.
  - All registered outputs 0, including if_rdata and mem_rdata.
  - An in-flight access is abandoned; no ack is generated for it. A RAM write already issued may still complete in the RAM.
- FSM states:
  - IDLE: arbitrate. If any request is pending, go to WAIT; otherwise stay.
  - WAIT: entered with the registered RAM strobes set. ram_en (and ram_we for writes) are high in the first WAIT cycle only; ram_addr/ram_wdata are held for the whole access. The counter runs from 0 to LATENCY. At the clock edge ending the cycle in which counter==LATENCY, ram_rdata is captured into the owner's rdata register; go to ACK.
  - ACK: the owner's ack is 1 for this single cycle; next state is IDLE.
- Timing:
  - Request first seen in IDLE at cycle t: ram_en at t+1, data at t+1+LATENCY, ack at t+2+LATENCY, IDLE again at t+3+LATENCY.
  - Peak throughput is one access per LATENCY+3 cycles.
- Arbitration in IDLE:
  - MEM wins over IF, unless IF is pending and streak==MAX_STREAK, in which case IF wins.
  - A MEM grant with IF pending increments streak (saturating). Any IF grant, or IF not pending, clears streak.
- Write/read semantics:
  - A write is acked after the same LATENCY as a read; mem_rdata is not updated on writes.
  - mem_ren=mem_wen=1 at grant: the access is performed as a write and conflict pulses in the first WAIT cycle.
- Requester protocol:
  - A requester must drop or renew its request in the cycle after its ack.
  - A request high in the IDLE cycle after an ack is treated as a new access.
- Requests that drop before being granted are ignored. Changes to address or data after grant are ignored, because these values are latched at grant.
- Owner tag: a 1-bit owner register, set at grant, routes the captured data and ack.

Decomposition:
- Shared package/include holds:
  - State encodings ARB_IDLE=2'd0, ARB_WAIT=2'd1, ARB_ACK=2'd2.
  - Owner codes OWN_IF=1'b0, OWN_MEM=1'b1.
- One sub-module is natural: arb_priority. It is the combinational grant decision from if_req, the MEM request and streak, plus the streak update.
- The FSM, counter and datapath registers stay in mem_arbiter.

Test Plan:
- Reset and single IF read:
  - Stimulus: LATENCY=2, RAM preset word 0x10=0xDEADBEEF; hold if_req=1, if_addr=0x10 from cycle 0.
  - Required: ram_en=1, ram_we=0 at cycle 1; if_ack=1 and if_rdata=0xDEADBEEF at cycle 4 only; stall_if=1 for cycles 0–3.
- Simultaneous requests:
  - Stimulus: if_req and mem_ren asserted together at cycle 0.
  - Required: MEM is served first (mem_ack at cycle 4); IF is granted in the IDLE cycle 5 and receives if_ack at cycle 9.
- Write then read:
  - Stimulus: mem_wen, mem_addr=0x20, mem_wdata=0x12345678; then mem_ren to 0x20.
  - Required: ram_we pulses once; the read returns 0x12345678; mem_rdata is unchanged during the write's ack.
- Fairness:
  - Stimulus: MAX_STREAK=4; IF held pending while MEM requests back-to-back.
  - Required: exactly 4 mem_acks, then if_ack, then MEM resumes.
- Conflict:
  - Stimulus: mem_ren=mem_wen=1.
  - Required: the access is a write; conflict=1 for exactly 1 cycle (cycle 1).
- Mid-access reset:
  - Stimulus: rst_n=0 at cycle 2 of an IF access.
  - Required: all outputs 0 immediately, with no if_ack; after release, a fresh request completes normally.
